// File: rtl/layer_scheduler.sv
// Layer scheduler: time-multiplexes one shared neuron compute unit across every neuron of a
// layer, with valid/ready handshakes for the input vector and for the collected result vector.
module layer_scheduler #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_NEURONS    = 8,
  parameter int TIMEOUT_CYCLES = 64,
  localparam int IDX_W         = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  output logic                                  load_inputs,
  output logic                                  nu_start,
  output logic [IDX_W-1:0]                      nu_index,
  input  logic                                  nu_done,
  input  logic signed [DATA_WIDTH-1:0]          nu_result,
  output logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0] results,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  busy,
  output logic                                  timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_NEURONS - 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO  = {IDX_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_OUTPUT = 2'd3
  } state_t;

  state_t                                 state_r;
  state_t                                 state_s;
  logic [IDX_W-1:0]                       idx_r;
  logic [IDX_W-1:0]                       idx_s;
  logic [CNT_W-1:0]                       cnt_r;
  logic [CNT_W-1:0]                       cnt_s;
  logic                                   timeout_s;
  logic                                   cap_en_s;
  logic [DATA_WIDTH-1:0]                  cap_val_s;
  logic                                   err_set_s;
  logic                                   in_ready_r;
  logic                                   nu_start_r;
  logic                                   out_valid_r;
  logic                                   busy_r;
  logic [IDX_W-1:0]                       nu_index_r;
  logic                                   timeout_err_r;
  logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0] results_r;

  // Expiry of the per-neuron wait window; a done in the same cycle takes priority.
  assign timeout_s = (state_r == ST_WAIT) && (cnt_r == LAST_WAIT) && !nu_done;

  // Next-state, index, wait counter and capture decisions.
  always_comb begin
    state_s   = state_r;
    idx_s     = idx_r;
    cnt_s     = cnt_r;
    cap_en_s  = 1'b0;
    cap_val_s = {DATA_WIDTH{1'b0}};
    err_set_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          idx_s   = IDX_ZERO;
          state_s = ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        cnt_s   = CNT_ZERO;
        state_s = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_s = cnt_r + CNT_W'(1);
        if (nu_done || timeout_s) begin
          cap_en_s = 1'b1;
          if (nu_done) begin
            cap_val_s = nu_result;
          end else begin
            err_set_s = 1'b1;
          end
          if (idx_r == LAST_IDX) begin
            state_s = ST_OUTPUT;
          end else begin
            idx_s   = idx_r + IDX_W'(1);
            state_s = ST_ISSUE;
          end
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_OUTPUT: begin
        if (out_ready) begin
          idx_s   = IDX_ZERO;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_OUTPUT;
        end
      end
      default: begin
        idx_s   = IDX_ZERO;
        cnt_s   = CNT_ZERO;
        state_s = ST_IDLE;
      end
    endcase
  end

  // State, index and wait counter registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      idx_r   <= IDX_ZERO;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      cnt_r   <= cnt_s;
    end
  end

  // Output flags are decoded from the next state so they align with the state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      in_ready_r  <= 1'b1;
      nu_start_r  <= 1'b0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      nu_index_r  <= IDX_ZERO;
    end else begin
      in_ready_r  <= (state_s == ST_IDLE);
      nu_start_r  <= (state_s == ST_ISSUE);
      out_valid_r <= (state_s == ST_OUTPUT);
      busy_r      <= (state_s != ST_IDLE);
      nu_index_r  <= (state_s == ST_IDLE) ? IDX_ZERO : idx_s;
    end
  end

  // Result slots only change on a WAIT completion (done or timeout).
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      results_r <= {(NUM_NEURONS * DATA_WIDTH){1'b0}};
    end else if (cap_en_s) begin
      results_r[idx_r] <= cap_val_s;
    end else begin
      results_r <= results_r;
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      timeout_err_r <= 1'b0;
    end else if (err_set_s) begin
      timeout_err_r <= 1'b1;
    end else begin
      timeout_err_r <= timeout_err_r;
    end
  end

  assign in_ready    = in_ready_r;
  assign load_inputs = in_valid & in_ready_r;
  assign nu_start    = nu_start_r;
  assign nu_index    = nu_index_r;
  assign results     = results_r;
  assign out_valid   = out_valid_r;
  assign busy        = busy_r;
  assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_layer_scheduler.sv
// Scoreboard bench for layer_scheduler: a 4-neuron instance with a short timeout under
// directed and random layers, plus a single-neuron instance.
module tb_layer_scheduler;
  localparam int N  = 4;
  localparam int TO = 8;
  localparam int DW = 32;

  typedef struct {
    logic [N-1:0][DW-1:0] res;
    logic                 err;
    int                   cyc;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  logic in_valid, in_ready, load_inputs, nu_start, nu_done, out_valid, out_ready, busy, timeout_err;
  logic [1:0] nu_index;
  logic [DW-1:0] nu_result;
  logic [N-1:0][DW-1:0] results;

  logic reset1, in_valid1, in_ready1, load_inputs1, nu_start1, nu_done1, out_valid1, out_ready1;
  logic busy1, timeout_err1;
  logic [0:0] nu_index1;
  logic [DW-1:0] nu_result1;
  logic [0:0][DW-1:0] results1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int plan_d [N];
  logic [DW-1:0] plan_v [N];
  exp_t exp_q[$];
  int iss_cyc_q[$];
  int iss_idx_q[$];
  bit spur = 1'b0;
  bit err_model = 1'b0;
  bit main_done = 1'b0;
  bit six_done = 1'b0;

  layer_scheduler #(.DATA_WIDTH(DW), .NUM_NEURONS(N), .TIMEOUT_CYCLES(TO)) u_dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .load_inputs(load_inputs), .nu_start(nu_start), .nu_index(nu_index), .nu_done(nu_done),
    .nu_result(nu_result), .results(results), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .timeout_err(timeout_err)
  );

  layer_scheduler #(.DATA_WIDTH(DW), .NUM_NEURONS(1), .TIMEOUT_CYCLES(64)) u_dut1 (
    .clock(clock), .reset(reset1), .in_valid(in_valid1), .in_ready(in_ready1),
    .load_inputs(load_inputs1), .nu_start(nu_start1), .nu_index(nu_index1), .nu_done(nu_done1),
    .nu_result(nu_result1), .results(results1), .out_valid(out_valid1), .out_ready(out_ready1),
    .busy(busy1), .timeout_err(timeout_err1)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // mode: 0 k=4 result 100+i; 1 idx2 silent; 2 idx1 done on last WAIT cycle;
  // 3 random; 4 random with silent neurons; 5 like 0 but reset during WAIT of idx 1.
  // hold: >0 cycles of out_ready=0 then 1, 0 immediate accept, <0 random out_ready.
  task automatic run_layer(input int mode, input int hold);
    exp_t e;
    int t, acc, n, eff;
    bit fin;
    for (int i = 0; i < N; i++) begin
      plan_d[i] = 4;
      plan_v[i] = 100 + i;
      if (mode >= 3 && mode <= 4) begin
        plan_d[i] = $urandom_range(1, TO);
        plan_v[i] = $urandom;
      end
      if (mode == 4 && $urandom_range(0, 5) == 0) plan_d[i] = 0;
    end
    if (mode == 1) plan_d[2] = 0;
    if (mode == 2) plan_d[1] = TO;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("idle_ready", in_ready, 1);
    in_valid = 1'b1;
    t = cyc;
    acc = t + 1;
    for (int i = 0; i < N; i++) begin
      e.res[i] = (plan_d[i] == 0) ? '0 : plan_v[i];
      iss_cyc_q.push_back(acc);
      iss_idx_q.push_back(i);
      eff = (plan_d[i] == 0) ? TO : plan_d[i];
      acc += eff + 1;
      if (plan_d[i] == 0) err_model = 1'b1;
    end
    e.err = err_model;
    e.cyc = acc;
    exp_q.push_back(e);
    #1 chk("load_hs", load_inputs, 1);
    fin = 1'b0;
    n = 0;
    while (!fin && n < 400) begin
      @(negedge clock);
      n++;
      if (mode == 5 && busy && !nu_start && nu_index == 2'd1) begin
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        iss_cyc_q.delete();
        iss_idx_q.delete();
        void'(exp_q.pop_back());
        err_model = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_nu_start", nu_start, 0);
        chk("rst_nu_index", nu_index, 0);
        chk("rst_results", results, 0);
        chk("rst_timeout_err", timeout_err, 0);
        spur = 1'b1;
        repeat (3) @(negedge clock);
        chk("spurious_done_results", results, 0);
        chk("spurious_done_busy", busy, 0);
        return;
      end
      chk("busy", busy, 1);
      chk("in_ready_busy", in_ready, 0);
      if (out_valid) begin
        if (hold > 0) begin
          out_ready = 1'b0;
          hold--;
        end else if (hold == 0) begin
          out_ready = 1'b1;
        end else begin
          out_ready = 1'($urandom_range(0, 1));
        end
        fin = out_ready;
      end else begin
        out_ready = 1'($urandom_range(0, 1));
      end
      in_valid = ($urandom_range(0, 2) == 0);
      #1 chk("load_busy", load_inputs, 0);
    end
    if (mode == 5) chk("reset_point_reached", 0, 1);
    if (!fin) chk("layer_finish_timeout", 0, 1);
    @(negedge clock);
    chk("ready_after_out", in_ready, 1);
    chk("out_valid_drop", out_valid, 0);
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  // Main stimulus for the 4-neuron instance.
  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_results", results, 0);
    chk("reset_out_valid", out_valid, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("post_reset_ready", in_ready, 1);
    run_layer(0, 0);
    run_layer(0, 10);
    run_layer(2, 0);
    repeat (6) run_layer(3, -1);
    run_layer(5, 0);
    run_layer(0, 0);
    run_layer(1, 0);
    repeat (10) run_layer(4, -1);
    repeat (5) @(negedge clock);
    chk("scoreboard_drained", exp_q.size(), 0);
    main_done = 1'b1;
  end

  // Neuron unit model: answers each start after the planned delay; silent when delay is 0.
  initial begin
    int cd = 0;
    logic [DW-1:0] v = '0;
    nu_done = 1'b0;
    nu_result = '0;
    forever begin
      @(negedge clock);
      nu_done = 1'b0;
      if (!busy) cd = 0;
      if (spur) begin
        spur = 1'b0;
        nu_done = 1'b1;
        nu_result = 32'h1234_5678;
      end
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          nu_done = 1'b1;
          nu_result = v;
        end
      end
      if (nu_start) begin
        if (iss_cyc_q.size() == 0) begin
          chk("unexpected_start", 1, 0);
        end else begin
          chk("start_cycle", cyc, iss_cyc_q.pop_front());
          chk("start_index", nu_index, iss_idx_q.pop_front());
        end
        cd = plan_d[nu_index];
        v = plan_v[nu_index];
      end
    end
  end

  // Output monitor: pops the scoreboard on each new result vector.
  initial begin
    bit prev = 1'b0;
    logic [N-1:0][DW-1:0] held = '0;
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev = 1'b0;
      end else if (out_valid && !prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_cycle", cyc, e.cyc);
          chk("results", results, e.res);
          chk("timeout_err", timeout_err, e.err);
        end
        held = results;
      end else if (out_valid) begin
        chk("results_held", results, held);
        chk("in_ready_in_output", in_ready, 0);
      end
      prev = out_valid;
    end
  end

  // Single-neuron instance: k=1, result -7.
  initial begin
    int t1;
    reset1 = 1'b1;
    in_valid1 = 1'b0;
    out_ready1 = 1'b1;
    nu_done1 = 1'b0;
    nu_result1 = '0;
    repeat (2) @(negedge clock);
    reset1 = 1'b0;
    repeat (2) @(negedge clock);
    chk("n1_ready", in_ready1, 1);
    in_valid1 = 1'b1;
    t1 = cyc;
    @(negedge clock);
    in_valid1 = 1'b0;
    chk("n1_start", nu_start1, 1);
    chk("n1_index", nu_index1, 0);
    @(negedge clock);
    chk("n1_start_pulse", nu_start1, 0);
    nu_done1 = 1'b1;
    nu_result1 = -32'sd7;
    @(negedge clock);
    nu_done1 = 1'b0;
    chk("n1_out_cycle", cyc - t1, 3);
    chk("n1_out_valid", out_valid1, 1);
    chk("n1_result", results1, 32'hFFFF_FFF9);
    @(negedge clock);
    chk("n1_out_drop", out_valid1, 0);
    chk("n1_ready_again", in_ready1, 1);
    six_done = 1'b1;
  end

  // Completion and global bound.
  initial begin
    while (!(main_done && six_done) && cyc < 60000) @(negedge clock);
    if (!(main_done && six_done)) chk("global_timeout", 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
